dispatch_ctrl: RTL and testbench



---
 rtl/dispatch_ctrl_pkg.sv | 50 +++++
 rtl/dispatch_skid_reg.sv | 50 +++++
 rtl/dispatch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch stage: functional-unit ids, dispatch FSM states,
// the decoded-instruction record and the buffer entry that carries it.
package dispatch_ctrl_pkg;

  localparam int NumFu = 6;

  typedef enum logic [2:0] {
    FU_ALU   = 3'd0,
    FU_MDU   = 3'd1,
    FU_LOAD  = 3'd2,
    FU_STORE = 3'd3,
    FU_BJU   = 3'd4,
    FU_CSR   = 3'd5
  } fu_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_DRAIN,
    WAIT_SER,
    WAIT_FLUSH
  } dispatch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decoder_t;

  typedef struct packed {
    decoder_t instr;
    logic     err;
  } buf_entry_t;

  // CSR, ECALL, EBREAK, MRET, FENCE and FENCE_I are all steered to the CSR unit.
  function automatic logic is_serializing(input fu_t fu);
    return fu == FU_CSR;
  endfunction

  function automatic logic [NumFu-1:0] fu_onehot(input fu_t fu);
    logic [NumFu-1:0] oh;
    oh = '0;
    if (int'(fu) < NumFu) oh[fu] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dispatch_skid_reg.sv
// One-entry valid/ready holding register for a dispatch buffer entry.
// en_i lets the owner close the input side independently of occupancy.
module dispatch_skid_reg
  import dispatch_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  buf_entry_t in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output buf_entry_t out_data_o
);

  logic       valid_q, valid_d;
  buf_entry_t data_q, data_d;

  assign in_ready_o  = en_i && (!valid_q || out_ready_i);
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    // NOTE: defaults first so every path assigns both _d signals and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch stage: buffers one decoded instruction, steers it to its issue queue,
// serializes CSR-class ops and turns decode errors into an illegal-instruction token.
// Optional performance counters are built when DISPATCH_PERF_EN is defined.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  decoder_t         dec_instr_i,
  input  logic             dec_err_i,
  output logic [NumFu-1:0] iq_valid_o,
  input  logic [NumFu-1:0] iq_ready_i,
  output decoder_t         iq_instr_o,
  input  logic             rob_empty_i,
  input  logic             ser_done_i,
  output logic             illegal_o,
  output logic [31:0]      illegal_pc_o,
  output logic             stall_timeout_o
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]      perf_dispatched_o,
  output logic [31:0]      perf_stall_fu_o,
  output logic [31:0]      perf_stall_ser_o
`endif
);

  localparam int CntW = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DrainTimeout - 1);

  dispatch_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     illegal_pc_q, illegal_pc_d;
  logic            rdy_en_q;

  logic       buf_v, buf_ser, issue_ok, fire, accept_en, err_drop;
  buf_entry_t buf_e;

  dispatch_skid_reg u_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (flush_i),
    .en_i       (accept_en && rdy_en_q),
    .in_valid_i (dec_valid_i),
    .in_ready_o (dec_ready_o),
    .in_data_i  ({dec_instr_i, dec_err_i}),
    .out_valid_o(buf_v),
    .out_ready_i(fire || err_drop),
    .out_data_o (buf_e)
  );

  assign buf_ser         = is_serializing(buf_e.instr.fu);
  assign iq_instr_o      = buf_e.instr;
  assign illegal_o       = illegal_q;
  assign illegal_pc_o    = illegal_pc_q;
  assign stall_timeout_o = !flush_i && (state_q == WAIT_DRAIN) && (cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    illegal_d    = 1'b0;
    illegal_pc_d = illegal_pc_q;
    iq_valid_o   = '0;
    accept_en    = 1'b0;
    err_drop     = 1'b0;

    issue_ok = ((state_q == RUN) && (!buf_ser || rob_empty_i)) ||
               ((state_q == WAIT_DRAIN) && rob_empty_i);
    if (buf_v && !buf_e.err && issue_ok && !flush_i) iq_valid_o = fu_onehot(buf_e.instr.fu);
    fire = |(iq_valid_o & iq_ready_i);

    unique case (state_q)
      RUN: begin
        // A serializing or faulting entry keeps the input closed even as it leaves,
        // so nothing younger is captured before the op completes.
        accept_en = !(buf_v && (buf_ser || buf_e.err));
        if (buf_v && (buf_ser || buf_e.err)) begin
          if (!rob_empty_i)   state_d  = WAIT_DRAIN;
          else if (buf_e.err) err_drop = 1'b1;
          else if (fire)      state_d  = WAIT_SER;
        end
      end
      WAIT_DRAIN: begin
        cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        if (buf_v && buf_e.err && rob_empty_i) err_drop = 1'b1;
        else if (fire)                         state_d  = WAIT_SER;
      end
      WAIT_SER: begin
        if (ser_done_i) begin
          state_d   = RUN;
          accept_en = 1'b1;
        end
      end
      WAIT_FLUSH: ;
      default: state_d = RUN;
    endcase

    if (err_drop) begin
      illegal_d    = 1'b1;
      illegal_pc_d = buf_e.instr.pc;
      state_d      = WAIT_FLUSH;
    end

    if (flush_i) begin
      state_d   = RUN;
      cnt_d     = '0;
      illegal_d = 1'b0;
      accept_en = 1'b0;
      err_drop  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      illegal_q    <= 1'b0;
      illegal_pc_q <= '0;
      rdy_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      illegal_q    <= illegal_d;
      illegal_pc_q <= illegal_pc_d;
      rdy_en_q     <= 1'b1;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp_q, perf_disp_d;
  logic [31:0] perf_fu_q, perf_fu_d;
  logic [31:0] perf_ser_q, perf_ser_d;

  always_comb begin
    perf_disp_d = perf_disp_q + {31'd0, fire};
    perf_fu_d   = perf_fu_q + {31'd0, (state_q == RUN) && buf_v && !fire};
    perf_ser_d  = perf_ser_q + {31'd0, (state_q == WAIT_DRAIN) || (state_q == WAIT_SER)};
  end

  // Flush leaves these alone: they describe the whole run, not one speculation window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_disp_q <= '0;
      perf_fu_q   <= '0;
      perf_ser_q  <= '0;
    end else begin
      perf_disp_q <= perf_disp_d;
      perf_fu_q   <= perf_fu_d;
      perf_ser_q  <= perf_ser_d;
    end
  end

  assign perf_dispatched_o = perf_disp_q;
  assign perf_stall_fu_o   = perf_fu_q;
  assign perf_stall_ser_o  = perf_ser_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a per-cycle vector table plus hand-written
// sequences for reset, the drain timeout and asynchronous reset mid-operation.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             dec_valid_i;
  logic             dec_ready_o;
  decoder_t         dec_instr_i;
  logic             dec_err_i;
  logic [NumFu-1:0] iq_valid_o;
  logic [NumFu-1:0] iq_ready_i;
  decoder_t         iq_instr_o;
  logic             rob_empty_i;
  logic             ser_done_i;
  logic             illegal_o;
  logic [31:0]      illegal_pc_o;
  logic             stall_timeout_o;
`ifdef DISPATCH_PERF_EN
  logic [31:0]      perf_dispatched_o, perf_stall_fu_o, perf_stall_ser_o;
`endif

  always #5 clk_i = ~clk_i;

  dispatch_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .dec_valid_i    (dec_valid_i),
    .dec_ready_o    (dec_ready_o),
    .dec_instr_i    (dec_instr_i),
    .dec_err_i      (dec_err_i),
    .iq_valid_o     (iq_valid_o),
    .iq_ready_i     (iq_ready_i),
    .iq_instr_o     (iq_instr_o),
    .rob_empty_i    (rob_empty_i),
    .ser_done_i     (ser_done_i),
    .illegal_o      (illegal_o),
    .illegal_pc_o   (illegal_pc_o),
    .stall_timeout_o(stall_timeout_o)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_dispatched_o(perf_dispatched_o),
    .perf_stall_fu_o  (perf_stall_fu_o),
    .perf_stall_ser_o (perf_stall_ser_o)
`endif
  );

  typedef struct {
    logic        flush, dv, err, rob, ser;
    fu_t         fu;
    logic [31:0] pc;
    logic [5:0]  rdy;
    logic        e_dr;
    logic [5:0]  e_iv;
    logic        e_ill;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic flush, input logic dv, input fu_t fu, input logic [31:0] pc,
                     input logic err, input logic [5:0] rdy, input logic rob, input logic ser,
                     input logic e_dr, input logic [5:0] e_iv, input logic e_ill,
                     input logic [31:0] e_pc);
    vec_t v;
    v.flush = flush; v.dv = dv; v.fu = fu; v.pc = pc; v.err = err; v.rdy = rdy;
    v.rob = rob; v.ser = ser; v.e_dr = e_dr; v.e_iv = e_iv; v.e_ill = e_ill; v.e_pc = e_pc;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    flush_i        = v.flush;
    dec_valid_i    = v.dv;
    dec_err_i      = v.err;
    iq_ready_i     = v.rdy;
    rob_empty_i    = v.rob;
    ser_done_i     = v.ser;
    dec_instr_i    = '0;
    dec_instr_i.pc = v.pc;
    dec_instr_i.fu = v.fu;
    dec_instr_i.op = v.pc[7:0];
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; dec_valid_i = 1'b0; dec_err_i = 1'b0; iq_ready_i = 6'h3F;
    rob_empty_i = 1'b1; ser_done_i = 1'b0; dec_instr_i = '0;
  endtask

  initial begin
    int pulses;
    int pulse_at;

    // flush dv fu pc err rdy rob ser | dec_ready iq_valid illegal pc
    // ALU then LOAD back-to-back
    add(0,1,FU_ALU,  32'h100,0,6'h3F,1,0, 1,6'h00,0,0);
    add(0,1,FU_LOAD, 32'h104,0,6'h3F,1,0, 1,6'h01,0,32'h100);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h04,0,32'h104);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h00,0,0);
    // MDU back-pressured for 3 cycles
    add(0,1,FU_MDU,  32'h200,0,6'h3F,1,0, 1,6'h00,0,0);
    add(0,0,FU_ALU,  32'h0,  0,6'h3D,1,0, 0,6'h02,0,32'h200);
    add(0,0,FU_ALU,  32'h0,  0,6'h3D,1,0, 0,6'h02,0,32'h200);
    add(0,0,FU_ALU,  32'h0,  0,6'h3D,1,0, 0,6'h02,0,32'h200);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h02,0,32'h200);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h00,0,0);
    // CSR waits 5 cycles for ROB drain, younger ADD held until ser_done
    add(0,1,FU_CSR,  32'h300,0,6'h3F,0,0, 1,6'h00,0,0);
    for (int k = 0; k < 5; k++) add(0,1,FU_ALU,32'h304,0,6'h3F,0,0, 0,6'h00,0,0);
    add(0,1,FU_ALU,  32'h304,0,6'h3F,1,0, 0,6'h20,0,32'h300);
    add(0,1,FU_ALU,  32'h304,0,6'h3F,1,0, 0,6'h00,0,0);
    add(0,1,FU_ALU,  32'h304,0,6'h3F,1,0, 0,6'h00,0,0);
    add(0,1,FU_ALU,  32'h304,0,6'h3F,1,1, 1,6'h00,0,0);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h01,0,32'h304);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,1, 1,6'h00,0,0);
    // decode error -> one illegal pulse, then stuck until flush
    add(0,1,FU_ALU,  32'h80000010,1,6'h3F,1,0, 1,6'h00,0,0);
    add(0,1,FU_ALU,  32'h400,0,6'h3F,1,0, 0,6'h00,0,0);
    add(0,1,FU_ALU,  32'h400,0,6'h3F,1,0, 0,6'h00,1,32'h80000010);
    add(0,1,FU_ALU,  32'h400,0,6'h3F,1,0, 0,6'h00,0,0);
    add(0,1,FU_ALU,  32'h400,0,6'h3F,1,0, 0,6'h00,0,0);
    add(1,1,FU_ALU,  32'h400,0,6'h3F,1,0, 0,6'h00,0,0);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h00,0,0);
    // flush in WAIT_DRAIN coinciding with rob_empty
    add(0,1,FU_CSR,  32'h500,0,6'h3F,0,0, 1,6'h00,0,0);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,0,0, 0,6'h00,0,0);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,0,0, 0,6'h00,0,0);
    add(1,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 0,6'h00,0,0);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h00,0,0);
    // CSR with empty ROB issues at once; younger op accepted with ser_done
    add(0,1,FU_CSR,  32'h600,0,6'h3F,1,0, 1,6'h00,0,0);
    add(0,1,FU_ALU,  32'h604,0,6'h3F,1,0, 0,6'h20,0,32'h600);
    add(0,1,FU_ALU,  32'h604,0,6'h3F,1,1, 1,6'h00,0,0);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h01,0,32'h604);
    // STORE and BJU routing
    add(0,1,FU_STORE,32'h700,0,6'h3F,1,0, 1,6'h00,0,0);
    add(0,1,FU_BJU,  32'h704,0,6'h3F,1,0, 1,6'h08,0,32'h700);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h10,0,32'h704);
    add(0,0,FU_ALU,  32'h0,  0,6'h3F,1,0, 1,6'h00,0,0);

    // reset
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst dec_ready", dec_ready_o, 0);
    check("rst iq_valid", iq_valid_o, 0);
    check("rst illegal", illegal_o, 0);
    check("rst illegal_pc", illegal_pc_o, 0);
    check("rst stall_timeout", stall_timeout_o, 0);
    check("rst iq_instr", iq_instr_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("post-rst dec_ready", dec_ready_o, 1);

    // table
    foreach (vq[i]) begin
      @(posedge clk_i);
      #1;
      drive(vq[i]);
      @(negedge clk_i);
      check($sformatf("v%0d dec_ready", i), dec_ready_o, vq[i].e_dr);
      check($sformatf("v%0d iq_valid", i), iq_valid_o, vq[i].e_iv);
      check($sformatf("v%0d illegal", i), illegal_o, vq[i].e_ill);
      check($sformatf("v%0d stall_timeout", i), stall_timeout_o, 0);
      if (vq[i].e_iv != 0) check($sformatf("v%0d iq_pc", i), iq_instr_o.pc, vq[i].e_pc);
      if (vq[i].e_ill) check($sformatf("v%0d illegal_pc", i), illegal_pc_o, vq[i].e_pc);
    end

    // drain timeout: one pulse in the 1024th WAIT_DRAIN cycle
    @(posedge clk_i);
    #1;
    idle_inputs();
    rob_empty_i    = 1'b0;
    dec_valid_i    = 1'b1;
    dec_instr_i.fu = FU_CSR;
    dec_instr_i.pc = 32'h900;
    @(posedge clk_i);
    #1;
    dec_valid_i = 1'b0;
    pulses = 0;
    pulse_at = -1;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk_i);
      if (iq_valid_o != 0) check($sformatf("drain c%0d iq_valid", k), iq_valid_o, 0);
      if (stall_timeout_o) begin
        pulses++;
        pulse_at = k;
      end
      @(posedge clk_i);
      #1;
    end
    check("timeout pulse count", pulses, 1);
    check("timeout pulse cycle", pulse_at, 1024);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("post-timeout flush dec_ready", dec_ready_o, 1);

    // asynchronous reset while an MDU op is held back
    @(posedge clk_i);
    #1;
    iq_ready_i     = 6'h00;
    dec_valid_i    = 1'b1;
    dec_instr_i.fu = FU_MDU;
    dec_instr_i.pc = 32'hA00;
    @(posedge clk_i);
    #1;
    dec_valid_i = 1'b0;
    @(negedge clk_i);
    check("pre-arst iq_valid", iq_valid_o, 6'h02);
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst iq_valid", iq_valid_o, 0);
    check("arst dec_ready", dec_ready_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    iq_ready_i = 6'h3F;
    @(posedge clk_i);
    @(negedge clk_i);
    check("post-arst iq_valid", iq_valid_o, 0);
    check("post-arst dec_ready", dec_ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
